apb_cmd_master: RTL

APB requester that turns a valid/ready command stream (write or read, 32-bit address and data) into single APB transfers toward the I2C controller's register slave. It returns one response per command with read data and a timeout error flag. It sits between a host-side sequencer or bridge and the `apb_*` port of the I2C register block. It issues strictly one transfer at a time and tolerates slave wait states.

---
 rtl/apb_cmd_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a valid/ready command stream into single APB transfers, one response each.
// Latency: command accept to rsp_valid is 3 cycles, plus one cycle per slave wait state.
// Backpressure: cmd_ready only in IDLE with no pending response; response held stable until rsp_ready.
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN (wait counter, timeout abort, rsp_err, err_cnt).
module apb_cmd_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  err_cnt,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [31:0] apb_addr,
  output logic [31:0] apb_wdata,
  input  logic        apb_ready,
  input  logic [31:0] apb_rdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        apb_write_q, apb_write_d;
  logic [31:0] apb_addr_q, apb_addr_d;
  logic [31:0] apb_wdata_q, apb_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // High in the ACCESS cycle where the slave has used up its wait allowance
  logic        timeout_hit;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Compare happens before the increment, so apb_en stays high TIMEOUT+1 cycles
  assign timeout_hit = (state_q == ACCESS) && !apb_ready && (wait_cnt_q == TIMEOUT_W);

  // Wait counter clears as a new transfer starts and saturates instead of wrapping; err_cnt saturates at 255
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_cnt_d  = err_cnt_q;
    if ((state_q == IDLE) && cmd_valid) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !apb_ready && (wait_cnt_q != 16'hFFFF)) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
    if (timeout_hit && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Timeout bookkeeping registers; err_cnt only clears on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Without the timeout feature ACCESS waits for apb_ready indefinitely
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err_cnt        = '0;
`endif

  // State and transfer registers; synchronous reset drops any in-flight transfer or pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      apb_write_q <= 1'b0;
      apb_addr_q  <= '0;
      apb_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      apb_write_q <= apb_write_d;
      apb_addr_q  <= apb_addr_d;
      apb_wdata_q <= apb_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state: one transfer at a time, response must be consumed before the next command
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb_ready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the command on accept, capture the response when the transfer ends
  always_comb begin
    apb_write_d = apb_write_q;
    apb_addr_d  = apb_addr_q;
    apb_wdata_d = apb_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if ((state_q == IDLE) && cmd_valid) begin
      apb_write_d = cmd_write;
      apb_addr_d  = cmd_addr;
      apb_wdata_d = cmd_wdata;
    end
    if (state_q == ACCESS) begin
      if (apb_ready) begin
        rsp_rdata_d = apb_write_q ? 32'd0 : apb_rdata;
        rsp_err_d   = 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b1;
      end
    end
  end

  // Outputs decoded from state; cmd_ready is also masked by reset
  always_comb begin
    cmd_ready = (state_q == IDLE) && !rst;
    apb_sel   = (state_q == SETUP) || (state_q == ACCESS);
    apb_en    = (state_q == ACCESS);
    rsp_valid = (state_q == RESP);
  end

  assign apb_write = apb_write_q;
  assign apb_addr  = apb_addr_q;
  assign apb_wdata = apb_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
